mac_dot_accum: RTL and testbench

- Parametrised, pipelined multiply-accumulate block; successor to the team's fixed 8-bit signed MAC.
- Computes a LANES-wide dot product of dataa·datab each accepted cycle and adds it to a running accumulator, or reloads the accumulator with it.
- Adds a runtime signed/unsigned mode, valid handshake, clock enable and a sticky overflow flag.
- Used as the arithmetic core for filter and dot-product datapaths.

---
 rtl/mac_dot_accum.sv | 152 +++++++++++++++
 tb/tb_mac_dot_accum.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_accum.sv
// mac_dot_accum: parametrised, 3-stage pipelined dot-product multiply-accumulate.
//
// Each accepted beat forms sum_i(dataa[i] * datab[i]) over LANES lanes and either
// adds it to the running accumulator or reloads the accumulator with it (sload).
// Operands are treated as two's complement or unsigned per beat (is_signed).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, ACTIVE-HIGH despite its name (1 = reset)
//   clken      pipeline enable; 0 freezes every register
//   in_valid   input beat valid
//   sload      with in_valid: load accumulator with this beat's dot product
//   is_signed  1 = operands two's complement, 0 = unsigned
//   dataa      LANES*DATA_W, lane i at [i*DATA_W +: DATA_W]
//   datab      same packing as dataa
//   acc_out    signed accumulator value
//   out_valid  acc_out updated this cycle
//   overflow   sticky accumulate overflow
//
// Build option:
//   MAC_DOT_ACCUM_SATURATE_EN  when defined, an overflowing result clamps to the
//                              signed ACC_W limits instead of wrapping.

module mac_dot_accum #(
  parameter int DATA_W = 8,
  parameter int LANES  = 2,
  parameter int ACC_W  = 20
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clken,
  input  logic                      in_valid,
  input  logic                      sload,
  input  logic                      is_signed,
  input  logic [LANES*DATA_W-1:0]   dataa,
  input  logic [LANES*DATA_W-1:0]   datab,
  output logic signed [ACC_W-1:0]   acc_out,
  output logic                      out_valid,
  output logic                      overflow
);

  localparam int LOG_L  = $clog2(LANES);
  localparam int OPND_W = DATA_W + 1;
  localparam int PROD_W = 2 * OPND_W;
  localparam int SUM_W  = PROD_W + LOG_L;
  // Working width for the accumulate: wide enough to hold both the
  // sign-extended accumulator plus one carry bit and the full-precision sum,
  // so the overflow test below sees the exact true result.
  localparam int EXT_W  = ((SUM_W > ACC_W + 1) ? SUM_W : ACC_W + 1) + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Stage 1 registers
  logic [LANES*DATA_W-1:0] s1_a;
  logic [LANES*DATA_W-1:0] s1_b;
  logic                    s1_valid;
  logic                    s1_sload;
  logic                    s1_signed;

  // Stage 2 registers
  logic signed [SUM_W-1:0] s2_sum;
  logic                    s2_valid;
  logic                    s2_sload;

  // Stage 2 combinational dot product
  logic signed [SUM_W-1:0]  sum_comb;
  logic signed [OPND_W-1:0] a_ext;
  logic signed [OPND_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;

  // Stage 3 combinational accumulate
  logic signed [EXT_W-1:0]  acc_wide;
  logic signed [EXT_W-1:0]  sum_wide;
  logic signed [EXT_W-1:0]  res_wide;
  logic signed [ACC_W-1:0]  res_trunc;
  logic signed [ACC_W-1:0]  acc_next;
  logic                     res_ovf;

  // Each lane operand gets one extra bit so signed and unsigned values share
  // a single signed multiplier: the top bit is the sign bit when is_signed,
  // otherwise zero.
  always_comb begin
    sum_comb = '0;
    a_ext    = '0;
    b_ext    = '0;
    prod     = '0;
    for (int i = 0; i < LANES; i++) begin
      a_ext    = {s1_signed & s1_a[i*DATA_W + DATA_W - 1], s1_a[i*DATA_W +: DATA_W]};
      b_ext    = {s1_signed & s1_b[i*DATA_W + DATA_W - 1], s1_b[i*DATA_W +: DATA_W]};
      prod     = a_ext * b_ext;
      sum_comb = sum_comb + SUM_W'(prod);
    end
  end

  // Overflow means the exact result does not survive truncation to ACC_W,
  // i.e. re-extending the truncated value does not reproduce it.
  always_comb begin
    acc_wide  = EXT_W'(acc_out);
    sum_wide  = EXT_W'(s2_sum);
    res_wide  = s2_sload ? sum_wide : (acc_wide + sum_wide);
    res_trunc = res_wide[ACC_W-1:0];
    res_ovf   = (res_wide != EXT_W'(res_trunc));
`ifdef MAC_DOT_ACCUM_SATURATE_EN
    if (res_ovf) begin
      acc_next = res_wide[EXT_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_next = res_trunc;
    end
`else
    acc_next = res_trunc;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_a      <= '0;
      s1_b      <= '0;
      s1_valid  <= 1'b0;
      s1_sload  <= 1'b0;
      s1_signed <= 1'b0;
      s2_sum    <= '0;
      s2_valid  <= 1'b0;
      s2_sload  <= 1'b0;
      acc_out   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (clken) begin
      s1_a      <= dataa;
      s1_b      <= datab;
      s1_valid  <= in_valid;
      s1_sload  <= sload;
      s1_signed <= is_signed;

      s2_sum    <= sum_comb;
      s2_valid  <= s1_valid;
      s2_sload  <= s1_sload;

      out_valid <= s2_valid;
      if (s2_valid) begin
        acc_out <= acc_next;
        // Sticky flag: any overflow sets it, only a clean reload clears it.
        if (res_ovf) begin
          overflow <= 1'b1;
        end else if (s2_sload) begin
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_accum.sv
// tb_mac_dot_accum: self-checking bench for mac_dot_accum with a scoreboard.
// Expected accumulator/overflow values are computed by a behavioural model
// when each beat is driven and compared when out_valid reports a new result.

module tb_mac_dot_accum;

  localparam int DATA_W = 8;
  localparam int LANES  = 2;
  localparam int ACC_W  = 20;

  localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));
  localparam longint MODV = longint'(1) <<< ACC_W;

  logic                           clk;
  logic                           rst_n;
  logic                           clken;
  logic                           in_valid;
  logic                           sload;
  logic                           is_signed;
  logic [LANES*DATA_W-1:0]        dataa;
  logic [LANES*DATA_W-1:0]        datab;
  logic signed [ACC_W-1:0]        acc_out;
  logic                           out_valid;
  logic                           overflow;

  typedef struct {
    longint acc;
    logic   ovf;
  } exp_t;

  exp_t   sb[$];
  longint model_acc;
  logic   model_ovf;
  int     errors;
  int     checks;

  mac_dot_accum #(
    .DATA_W(DATA_W),
    .LANES (LANES),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clken    (clken),
    .in_valid (in_valid),
    .sload    (sload),
    .is_signed(is_signed),
    .dataa    (dataa),
    .datab    (datab),
    .acc_out  (acc_out),
    .out_valid(out_valid),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic longint dotModel(input logic [LANES*DATA_W-1:0] a,
                                      input logic [LANES*DATA_W-1:0] b,
                                      input logic sg);
    longint total = 0;
    for (int i = 0; i < LANES; i++) begin
      logic [DATA_W-1:0] x;
      logic [DATA_W-1:0] y;
      longint xv;
      longint yv;
      x  = a[i*DATA_W +: DATA_W];
      y  = b[i*DATA_W +: DATA_W];
      xv = sg ? longint'($signed(x)) : longint'(x);
      yv = sg ? longint'($signed(y)) : longint'(y);
      total += xv * yv;
    end
    return total;
  endfunction

  // Update the reference accumulator for one accepted beat and queue the result.
  task automatic pushModel(input logic sl, input logic sg,
                           input logic [LANES*DATA_W-1:0] a,
                           input logic [LANES*DATA_W-1:0] b);
    longint truth;
    longint res;
    logic   fits;
    exp_t   e;
    truth = sl ? dotModel(a, b, sg) : model_acc + dotModel(a, b, sg);
    fits  = (truth >= MINV) && (truth <= MAXV);
    if (fits) begin
      res = truth;
    end else begin
`ifdef MAC_DOT_ACCUM_SATURATE_EN
      res = (truth < 0) ? MINV : MAXV;
`else
      res = truth % MODV;
      if (res < 0) res += MODV;
      if (res > MAXV) res -= MODV;
`endif
    end
    if (!fits) model_ovf = 1'b1;
    else if (sl) model_ovf = 1'b0;
    model_acc = res;
    e.acc = res;
    e.ovf = model_ovf;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs on the falling edge; accepted beats go to the model.
  task automatic applyStimulus(input logic v, input logic sl, input logic sg,
                               input logic [LANES*DATA_W-1:0] a,
                               input logic [LANES*DATA_W-1:0] b,
                               input logic en, input logic rst);
    @(negedge clk);
    in_valid  = v;
    sload     = sl;
    is_signed = sg;
    dataa     = a;
    datab     = b;
    clken     = en;
    rst_n     = rst;
    if (!rst && en && v) pushModel(sl, sg, a, b);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  // Monitor: one pass per rising edge, sampled 1 time unit after the edge.
  longint last_acc;
  logic   last_valid;
  logic   last_ovf;
  logic   en_s;
  logic   rst_s;
  exp_t   got;

  initial begin
    last_acc   = 0;
    last_valid = 1'b0;
    last_ovf   = 1'b0;
  end

  always @(posedge clk) begin
    en_s  = clken;
    rst_s = rst_n;
    #1;
    if (rst_s) begin
      sb.delete();
      model_acc = 0;
      model_ovf = 1'b0;
      checkOutput("rst_acc", longint'(acc_out), 0);
      checkOutput("rst_valid", longint'(out_valid), 0);
      checkOutput("rst_ovf", longint'(overflow), 0);
    end else if (!en_s) begin
      checkOutput("stall_acc", longint'(acc_out), last_acc);
      checkOutput("stall_valid", longint'(out_valid), longint'(last_valid));
      checkOutput("stall_ovf", longint'(overflow), longint'(last_ovf));
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", 1, 0);
      end else begin
        got = sb.pop_front();
        checkOutput("acc", longint'(acc_out), got.acc);
        checkOutput("ovf", longint'(overflow), longint'(got.ovf));
      end
    end else begin
      checkOutput("idle_acc", longint'(acc_out), last_acc);
      checkOutput("idle_ovf", longint'(overflow), longint'(last_ovf));
    end
    last_acc   = longint'(acc_out);
    last_valid = out_valid;
    last_ovf   = overflow;
  end

  initial begin
    errors    = 0;
    checks    = 0;
    model_acc = 0;
    model_ovf = 1'b0;
    rst_n     = 1'b1;
    clken     = 1'b1;
    in_valid  = 1'b1;
    sload     = 1'b0;
    is_signed = 1'b0;
    dataa     = '0;
    datab     = '0;

    // Reset held for two edges with in_valid high
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b1);
    idleCycles(2);

    // Signed reload then accumulate
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h00FF, 16'h0080, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0037, 16'h007F, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0087, 16'h0080, 1'b1, 1'b0);
    idleCycles(4);

    // Unsigned reload
    applyStimulus(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFF80, 1'b1, 1'b0);
    idleCycles(4);

    // Stall between two back-to-back beats, then stall with a result on the output
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0302, 16'h0405, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 16'h7F7F, 16'h7F7F, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0A0B, 16'h0C0D, 1'b1, 1'b0);
    idleCycles(2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    idleCycles(4);

    // Gapped beats
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hFE03, 16'h0709, 1'b1, 1'b0);
    idleCycles(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h1020, 16'h3040, 1'b1, 1'b0);
    idleCycles(4);

    // Overflow: 16 beats of 32768, one more accumulate, then a clean reload
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h8080, 16'h8080, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 1'b1, 16'h8080, 16'h8080, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h8080, 16'h8080, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0101, 16'h0101, 1'b1, 1'b0);
    idleCycles(4);

    // Reset with three beats in flight, then a fresh reload and accumulate
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h3333, 16'h4444, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h05FB, 16'h0607, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0203, 16'h0405, 1'b1, 1'b0);
    idleCycles(4);

    // Random mix of modes, reloads, gaps and stalls
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 1), 16'($urandom), 16'($urandom),
                    ($urandom_range(0, 4) != 0), 1'b0);
    end

    // Drain with a bounded wait
    for (int i = 0; i < 20 && sb.size() != 0; i++) idleCycles(1);
    idleCycles(1);
    checkOutput("drain", longint'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
